// File: rtl/axil_pkg.sv
// axil_pkg: shared response codes, read FSM states and address range check for the AXI-Lite data memory
package axil_pkg;
  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RD, R_RESP} rd_state_t;
  function automatic logic in_range(input logic [63:0] addr, input int depth, input int data_w);
    return addr < 64'(depth) * 64'(data_w / 8);
  endfunction
endpackage

// File: rtl/bytewise_ram.sv
// bytewise_ram: single-port RAM with per-byte write enables and a registered read port
module bytewise_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  parameter string INIT_F = ""
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic [DATA_W/8-1:0]       we,
  input  logic [$clog2(DEPTH)-1:0]  addr,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      for (int i = 0; i < DATA_W/8; i++)
        if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      dout <= mem[addr];
    end
endmodule

// File: rtl/axil_datamemory.sv
// axil_datamemory: AXI4-Lite slave data memory, one RAM shared by the write and read paths
// through a one-flop round-robin arbiter; every output comes straight from a register.
module axil_datamemory import axil_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH = 1024,
  parameter string INIT_F = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [2:0]          awprot,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                bvalid,
  input  logic                bready,
  output resp_t               bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [2:0]          arprot,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output resp_t               rresp
);
  localparam int SW = DATA_W / 8;
  localparam int OFF = $clog2(SW);
  localparam int RW = $clog2(DEPTH);
  logic aw_held, w_held, lg_write;
  logic [ADDR_W-1:0] aw_addr, ar_addr;
  logic [DATA_W-1:0] w_data, ram_dout;
  logic [SW-1:0] w_strb, ram_we;
  logic [RW-1:0] ram_addr;
  rd_state_t rs, rs_n;
  logic aw_hs, w_hs, ar_hs, r_hs, wr_req, rd_req, gw, gr;
  logic aw_held_n, w_held_n, b_pend_n, wr_ok, rd_ok, ram_en, unused_ok;
  assign aw_hs = awvalid & awready;
  assign w_hs = wvalid & wready;
  assign ar_hs = arvalid & arready;
  assign r_hs = rvalid & rready;
  assign wr_req = aw_held & w_held;
  assign rd_req = rs == R_REQ;
  // lg_write=0 means read was granted last, so a collision goes to the write
  assign gw = wr_req & (!rd_req | !lg_write);
  assign gr = rd_req & (!wr_req | lg_write);
  assign wr_ok = in_range(64'(aw_addr), DEPTH, DATA_W);
  assign rd_ok = in_range(64'(ar_addr), DEPTH, DATA_W);
  assign aw_held_n = gw ? 1'b0 : aw_held | aw_hs;
  assign w_held_n = gw ? 1'b0 : w_held | w_hs;
  assign b_pend_n = gw | (bvalid & !bready);
  assign ram_en = (gw & wr_ok) | (gr & rd_ok);
  assign ram_we = gw ? w_strb : '0;
  assign ram_addr = gw ? aw_addr[OFF +: RW] : ar_addr[OFF +: RW];
  assign unused_ok = ^{awprot, arprot, aw_addr, ar_addr};
  always_comb begin
    rs_n = rs;
    rs_n = rs == R_IDLE ? (ar_hs ? R_REQ : R_IDLE) :
           rs == R_REQ  ? (gr ? R_RD : R_REQ) :
           rs == R_RD   ? R_RESP :
           (r_hs ? R_IDLE : R_RESP);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rs <= R_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      lg_write <= 1'b0;
      awready <= 1'b0;
      wready <= 1'b0;
      arready <= 1'b0;
      bvalid <= 1'b0;
      bresp <= RESP_OKAY;
      rvalid <= 1'b0;
      rresp <= RESP_OKAY;
      rdata <= '0;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
    end else begin
      rs <= rs_n;
      aw_held <= aw_held_n;
      w_held <= w_held_n;
      awready <= !aw_held_n & !b_pend_n;
      wready <= !w_held_n & !b_pend_n;
      arready <= rs_n == R_IDLE;
      bvalid <= b_pend_n;
      rvalid <= rs_n == R_RESP;
      if (gw) bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (gw | gr) lg_write <= gw;
      if (aw_hs) aw_addr <= awaddr;
      if (w_hs) begin
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (ar_hs) ar_addr <= araddr;
      if (rs == R_RD) begin
        rdata <= rd_ok ? ram_dout : '0;
        rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  bytewise_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .INIT_F(INIT_F)) u_ram (
    .clk(clk),
    .en(ram_en),
    .we(ram_we),
    .addr(ram_addr),
    .din(w_data),
    .dout(ram_dout)
  );
endmodule

// File: tb/tb_axil_datamemory.sv
// tb_axil_datamemory: scoreboard bench for axil_datamemory with a 256-word memory
module tb_axil_datamemory;
  logic clk = 1'b0, reset = 1'b1;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic awready, wready, bvalid, arready, rvalid;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  int n_err = 0, n_chk = 0;
  logic [1:0] bq [$];
  logic [33:0] rq [$];
  logic [31:0] mem_m [256];
  always #5 clk = ~clk;
  axil_datamemory #(.DATA_W(32), .ADDR_W(12), .DEPTH(256)) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (bq.size() == 0) check("b_unexp", 64'(bvalid), 64'd0);
      else check("bresp", 64'(bresp), 64'(bq.pop_front()));
    end
    if (rvalid && rready) begin
      if (rq.size() == 0) check("r_unexp", 64'(rvalid), 64'd0);
      else check("rresp_rdata", 64'({rresp, rdata}), 64'(rq.pop_front()));
    end
  end
  task automatic exp_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    bq.push_back(a < 12'h400 ? 2'b00 : 2'b10);
    if (a < 12'h400)
      for (int i = 0; i < 4; i++) if (s[i]) mem_m[a[9:2]][8*i +: 8] = d[8*i +: 8];
  endtask
  task automatic exp_read(input logic [11:0] a);
    rq.push_back(a < 12'h400 ? {2'b00, mem_m[a[9:2]]} : {2'b10, 32'h0});
  endtask
  task automatic send_aw(input logic [11:0] a);
    int t = 0;
    awaddr = a;
    awvalid = 1'b1;
    do begin @(negedge clk); t++; end while (!awready && t < 100);
    check("aw_ready", 64'(awready), 64'd1);
    @(posedge clk); #1 awvalid = 1'b0;
  endtask
  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int t = 0;
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    do begin @(negedge clk); t++; end while (!wready && t < 100);
    check("w_ready", 64'(wready), 64'd1);
    @(posedge clk); #1 wvalid = 1'b0;
  endtask
  task automatic send_ar(input logic [11:0] a);
    int t = 0;
    araddr = a;
    arvalid = 1'b1;
    do begin @(negedge clk); t++; end while (!arready && t < 100);
    check("ar_ready", 64'(arready), 64'd1);
    @(posedge clk); #1 arvalid = 1'b0;
  endtask
  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_write(a, d, s);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask
  task automatic do_read(input logic [11:0] a);
    exp_read(a);
    send_ar(a);
  endtask
  task automatic drain;
    for (int i = 0; i < 100 && (bq.size() != 0 || rq.size() != 0); i++) @(negedge clk);
    check("drain", 64'(bq.size() + rq.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'({awready, wready, arready}), 64'd0);
    check("rst_valid", 64'({bvalid, rvalid}), 64'd0);
    check("rst_resp_data", 64'({bresp, rresp, rdata}), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rel_ready", 64'({awready, wready, arready}), 64'b111);
    // 1: same-cycle AW+W then read back, with latency checks
    do_write(12'h010, 32'hDEADBEEF, 4'hF);
    @(negedge clk) check("t1_b_early", 64'(bvalid), 64'd0);
    @(negedge clk) check("t1_b_lat", 64'(bvalid), 64'd1);
    drain();
    do_read(12'h010);
    @(negedge clk) check("t1_r_early0", 64'(rvalid), 64'd0);
    @(negedge clk) check("t1_r_early1", 64'(rvalid), 64'd0);
    @(negedge clk) check("t1_r_lat", 64'(rvalid), 64'd1);
    drain();
    // 2: W leads AW by 3 cycles, single-byte strobe
    exp_write(12'h010, 32'h0000AB00, 4'h2);
    send_w(32'h0000AB00, 4'h2);
    @(negedge clk);
    check("t2_w_drop", 64'(wready), 64'd0);
    check("t2_no_b", 64'(bvalid), 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    send_aw(12'h010);
    drain();
    do_read(12'h010);
    drain();
    check("t2_model", 64'(mem_m[4]), 64'hDEADABEF);
    // 3: out-of-range write must not alias onto the top word
    do_write(12'h3FC, 32'h12345678, 4'hF);
    drain();
    do_write(12'hFFC, 32'hCAFEF00D, 4'hF);
    drain();
    do_read(12'hFFC);
    drain();
    do_read(12'h3FC);
    drain();
    do_write(12'h000, 32'hA5A5A5A5, 4'h0);
    drain();
    // 4: write/read collision; last grant is a read so the write wins
    do_write(12'h020, 32'h11111111, 4'hF);
    drain();
    do_read(12'h020);
    drain();
    exp_write(12'h020, 32'h22222222, 4'hF);
    exp_read(12'h020);
    fork
      send_aw(12'h020);
      send_w(32'h22222222, 4'hF);
      send_ar(12'h020);
    join
    @(negedge clk);
    @(negedge clk) check("t4a_b", 64'(bvalid), 64'd1);
    @(negedge clk) check("t4a_r_late", 64'(rvalid), 64'd0);
    @(negedge clk) check("t4a_r", 64'(rvalid), 64'd1);
    drain();
    do_write(12'h030, 32'h30303030, 4'hF);
    drain();
    exp_read(12'h020);
    exp_write(12'h020, 32'h33333333, 4'hF);
    fork
      send_aw(12'h020);
      send_w(32'h33333333, 4'hF);
      send_ar(12'h020);
    join
    @(negedge clk);
    @(negedge clk) check("t4b_b_late", 64'(bvalid), 64'd0);
    @(negedge clk);
    check("t4b_r", 64'(rvalid), 64'd1);
    check("t4b_b", 64'(bvalid), 64'd1);
    drain();
    do_read(12'h020);
    drain();
    // 5: stalled B and R channels hold steady
    bready = 1'b0;
    rready = 1'b0;
    do_write(12'h040, 32'h55AA55AA, 4'hF);
    do_read(12'h010);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_valid", 64'({bvalid, rvalid}), 64'b11);
      check("t5_resp", 64'({bresp, rresp}), 64'd0);
      check("t5_rdata", 64'(rdata), 64'hDEADABEF);
      check("t5_ready", 64'({awready, wready, arready}), 64'd0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    rready = 1'b1;
    drain();
    // 6: reset while B is pending and the read sits in R_RD
    bready = 1'b0;
    do_write(12'h050, 32'h0BADC0DE, 4'hF);
    send_ar(12'h010);
    @(posedge clk); #1;
    check("t6_pre_b", 64'(bvalid), 64'd1);
    reset = 1'b0;
    #1;
    check("t6_valid", 64'({bvalid, rvalid}), 64'd0);
    check("t6_ready", 64'({awready, wready, arready}), 64'd0);
    check("t6_data", 64'({bresp, rresp, rdata}), 64'd0);
    bq.delete();
    rq.delete();
    repeat (2) @(posedge clk); #1;
    check("t6_hold_valid", 64'({bvalid, rvalid}), 64'd0);
    reset = 1'b1;
    bready = 1'b1;
    @(posedge clk); #1;
    do_read(12'h010);
    drain();
    do_read(12'h020);
    drain();
    do_read(12'h050);
    drain();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
